// File: rtl/ext_cpu_data_arbiter.sv
// ext_cpu_data_arbiter: shares one OBI data port between NHARTS cv32e20 data
// interfaces. Round-robin selection with combinational grant forwarding, a
// response-ID FIFO that routes rvalid/rdata back to the issuing hart, and a
// lock that keeps a presented-but-ungranted request sourced from one hart.
// Optional macro EXT_CPU_ARB_FIXED_PRIO_EN: fixed priority (lowest index wins).

package ext_cpu_data_arbiter_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module ext_cpu_data_arbiter
    import ext_cpu_data_arbiter_pkg::*;
#(
    parameter int unsigned NHARTS          = 3,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  obi_req_t                             core_req_i  [NHARTS],
    output obi_resp_t                            core_resp_o [NHARTS],
    output obi_req_t                             bus_req_o,
    input  obi_resp_t                            bus_resp_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 err_o
);

    localparam int unsigned HW = (NHARTS > 1) ? $clog2(NHARTS) : 1;
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [HW-1:0] rr_ptr_q, rr_ptr_d;
    logic          lock_q, lock_d;
    logic [HW-1:0] lock_id_q, lock_id_d;
    logic [HW-1:0] ids_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          err_q, err_d;

    logic          any_req;
    logic [HW-1:0] sel;
    logic          full;
    logic          handshake;
    logic          pop;
    logic [HW-1:0] head;

    assign full          = (occ_q == OW'(MAX_OUTSTANDING));
    assign head          = ids_q[rd_ptr_q];
    assign outstanding_o = occ_q;
    assign err_o         = err_q;

    // Select the locked hart, otherwise the first requester from rr_ptr_q onward
    always_comb begin : sel_comb
        logic        found;
        int unsigned idx;
        any_req = 1'b0;
        found   = 1'b0;
        sel     = '0;
        idx     = 0;
        for (int unsigned i = 0; i < NHARTS; i++) begin
            any_req = any_req | core_req_i[i].req;
        end
        if (lock_q) begin
            sel = lock_id_q;
        end else begin
            for (int unsigned i = 0; i < NHARTS; i++) begin
                idx = (32'(rr_ptr_q) + i) % NHARTS;
                if (!found && core_req_i[idx].req) begin
                    found = 1'b1;
                    sel   = HW'(idx);
                end
            end
        end
    end

    // Forward the selected request; withhold req while the ID FIFO is full
    always_comb begin
        bus_req_o = '0;
        if (any_req) begin
            bus_req_o     = core_req_i[sel];
            bus_req_o.req = ~full;
        end
    end

    assign handshake = bus_req_o.req & bus_resp_i.gnt;
    assign pop       = bus_resp_i.rvalid & (occ_q != '0);

    // Route gnt to the selected hart and rvalid/rdata to the FIFO head hart
    always_comb begin
        for (int unsigned i = 0; i < NHARTS; i++) begin
            core_resp_o[i] = '0;
        end
        if (handshake) begin
            core_resp_o[sel].gnt = 1'b1;
        end
        if (pop) begin
            core_resp_o[head].rvalid = 1'b1;
            core_resp_o[head].rdata  = bus_resp_i.rdata;
        end
    end

    // Next-state for arbitration, lock, FIFO pointers, occupancy and error flag
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        err_d     = err_q;

        if (handshake) begin
            lock_d = 1'b0;
`ifdef EXT_CPU_ARB_FIXED_PRIO_EN
            rr_ptr_d = '0;
`else
            rr_ptr_d = (32'(sel) == NHARTS - 1) ? '0 : sel + HW'(1);
`endif
            wr_ptr_d = (32'(wr_ptr_q) == MAX_OUTSTANDING - 1) ? '0 : wr_ptr_q + PW'(1);
        end else if (bus_req_o.req) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end

        if (pop) begin
            rd_ptr_d = (32'(rd_ptr_q) == MAX_OUTSTANDING - 1) ? '0 : rd_ptr_q + PW'(1);
        end

        case ({handshake, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase

        if (bus_resp_i.rvalid && (occ_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                ids_q[i] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            err_q     <= err_d;
            if (handshake) begin
                ids_q[wr_ptr_q] <= sel;
            end
        end
    end

endmodule

// File: tb/tb_ext_cpu_data_arbiter.sv
// Randomized scoreboard bench for ext_cpu_data_arbiter against a queue-based
// reference model of the arbitration, locking and response-routing rules.
// Build with EXT_CPU_ARB_FIXED_PRIO_EN to check the fixed-priority variant.

module tb_ext_cpu_data_arbiter;
    import ext_cpu_data_arbiter_pkg::*;

    localparam int NH  = 3;
    localparam int MO  = 2;
    localparam int OW  = $clog2(MO + 1);

    typedef struct {
        obi_req_t        bus;
        logic [OW-1:0]   occ;
        logic            err;
    } cyc_rec_t;

    typedef struct {
        int          hart;
        logic [31:0] rdata;
    } rsp_rec_t;

    logic          clk = 1'b0;
    logic          rst_i;
    obi_req_t      core_req  [NH];
    obi_resp_t     core_resp [NH];
    obi_req_t      bus_req;
    obi_resp_t     bus_resp;
    logic [OW-1:0] outstanding;
    logic          err;

    ext_cpu_data_arbiter #(.NHARTS(NH), .MAX_OUTSTANDING(MO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .core_req_i   (core_req),
        .core_resp_o  (core_resp),
        .bus_req_o    (bus_req),
        .bus_resp_i   (bus_resp),
        .outstanding_o(outstanding),
        .err_o        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    cyc_rec_t exp_cyc[$];
    int       exp_gnt[$];
    rsp_rec_t exp_rsp[$];

    // Reference model state
    int   m_rr   = 0;
    int   m_lock = -1;
    int   m_ids[$];
    bit   m_err  = 0;

    // Hart-side pending transactions (held stable until granted)
    bit          pend  [NH];
    obi_req_t    hreq  [NH];

    task automatic chk(input string name, input bit ok, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_lock = -1;
        m_ids.delete();
        m_err = 0;
        for (int h = 0; h < NH; h++) pend[h] = 0;
    endtask

    // One cycle of stimulus plus the model's expected response for it
    task automatic step(input int p_req, input int p_gnt, input int p_rv, input bit force_rv);
        int       sel;
        bit       any;
        bit       present;
        bit       hs;
        bit       rv;
        cyc_rec_t rec;
        @(negedge clk);
        rst_i = 1'b0;
        for (int h = 0; h < NH; h++) begin
            if (!pend[h] && ($urandom_range(99) < p_req)) begin
                pend[h]       = 1;
                hreq[h].req   = 1'b1;
                hreq[h].we    = 1'($urandom_range(1));
                hreq[h].be    = 4'($urandom);
                hreq[h].addr  = $urandom;
                hreq[h].wdata = $urandom;
            end
            if (pend[h]) core_req[h] = hreq[h];
            else begin
                core_req[h]       = obi_req_t'({$urandom, $urandom, $urandom});
                core_req[h].req   = 1'b0;
            end
        end
        rv = force_rv || ((m_ids.size() > 0) && ($urandom_range(99) < p_rv));
        bus_resp.gnt    = ($urandom_range(99) < p_gnt);
        bus_resp.rvalid = rv;
        bus_resp.rdata  = $urandom;

        any = 0;
        for (int h = 0; h < NH; h++) if (pend[h]) any = 1;
        sel = -1;
        if (m_lock >= 0) sel = m_lock;
        else for (int i = 0; i < NH; i++) if (sel < 0 && pend[(m_rr + i) % NH]) sel = (m_rr + i) % NH;
        present = any && (m_ids.size() < MO);
        hs = present && bus_resp.gnt;

        rec.bus = '0;
        if (any) begin
            rec.bus     = hreq[sel];
            rec.bus.req = present;
        end
        rec.occ = OW'(m_ids.size());
        rec.err = m_err;
        exp_cyc.push_back(rec);

        if (rv && m_ids.size() > 0) begin
            rsp_rec_t r;
            r.hart  = m_ids[0];
            r.rdata = bus_resp.rdata;
            exp_rsp.push_back(r);
            void'(m_ids.pop_front());
        end else if (rv) begin
            m_err = 1;
        end
        if (hs) begin
            exp_gnt.push_back(sel);
            m_ids.push_back(sel);
            pend[sel] = 0;
            m_lock = -1;
`ifdef EXT_CPU_ARB_FIXED_PRIO_EN
            m_rr = 0;
`else
            m_rr = (sel + 1) % NH;
`endif
        end else if (present) begin
            m_lock = sel;
        end
    endtask

    task automatic do_reset(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst_i = 1'b1;
            for (int h = 0; h < NH; h++) core_req[h] = '0;
            bus_resp = '0;
        end
        model_reset();
    endtask

    // Monitor: compare DUT outputs with whatever the stimulus side expects
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_i !== 1'b0) continue;
            if (exp_cyc.size() > 0) begin
                cyc_rec_t r;
                r = exp_cyc.pop_front();
                chk("bus_req", bus_req === r.bus, 128'(bus_req), 128'(r.bus));
                chk("outstanding", outstanding === r.occ, 128'(outstanding), 128'(r.occ));
                chk("err", err === r.err, 128'(err), 128'(r.err));
            end
            for (int h = 0; h < NH; h++) begin
                if (core_resp[h].gnt === 1'b1) begin
                    if (exp_gnt.size() == 0) chk("gnt_unexpected", 1'b0, 128'(h), 128'(-1));
                    else begin
                        int eh;
                        eh = exp_gnt.pop_front();
                        chk("gnt_hart", h == eh, 128'(h), 128'(eh));
                    end
                end
                if (core_resp[h].rvalid === 1'b1) begin
                    if (exp_rsp.size() == 0) chk("rvalid_unexpected", 1'b0, 128'(h), 128'(-1));
                    else begin
                        rsp_rec_t e;
                        e = exp_rsp.pop_front();
                        chk("rvalid_hart", h == e.hart, 128'(h), 128'(e.hart));
                        chk("rdata", core_resp[h].rdata === e.rdata, 128'(core_resp[h].rdata), 128'(e.rdata));
                    end
                end else begin
                    chk("rdata_idle", core_resp[h].rdata === 32'h0, 128'(core_resp[h].rdata), 128'(0));
                end
            end
        end
    end

    initial begin
        int guard;
        rst_i = 1'b1;
        bus_resp = '0;
        for (int h = 0; h < NH; h++) begin
            core_req[h] = '0;
            hreq[h]     = '0;
        end
        model_reset();
        do_reset(2);

        // Idle after reset
        repeat (4) step(0, 100, 0, 0);
        // Light traffic
        repeat (300) step(40, 70, 40, 0);
        // Saturating traffic: FIFO full stalls
        repeat (200) step(90, 90, 20, 0);
        // Reset with transactions in flight
        do_reset(1);
        repeat (5) step(0, 100, 0, 0);
        // Rare grants: long locks while other harts arrive
        repeat (200) step(70, 25, 50, 0);
        // All harts continuously, gnt every cycle
        repeat (100) step(100, 100, 100, 0);

        // Drain, then rvalid with an empty FIFO
        guard = 0;
        while (guard < 50 && (m_ids.size() > 0 || pend[0] || pend[1] || pend[2])) begin
            step(0, 100, 100, 0);
            guard++;
        end
        chk("drain_bound", guard < 50, 128'(guard), 128'(50));
        step(0, 0, 0, 1);
        repeat (5) step(30, 80, 40, 0);
        do_reset(1);
        repeat (4) step(0, 100, 0, 0);

        repeat (3) @(negedge clk);
        chk("gnt_queue_empty", exp_gnt.size() == 0, 128'(exp_gnt.size()), 128'(0));
        chk("rsp_queue_empty", exp_rsp.size() == 0, 128'(exp_rsp.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ext_cpu_data_arbiter.md
# ext_cpu_data_arbiter

Shares a single OBI data port of the external CPU system between `NHARTS` cv32e20 data interfaces. Round-robin arbitration with zero-cycle grant forwarding, an ID FIFO routing `rvalid`/`rdata` back to the issuing hart, and OBI request-stability locking. Sits between the per-hart `core_data_req_o`/`core_data_resp_i` arrays of the CPU system and one bus-side OBI master port.

## Interface
Parameters:
- `NHARTS`, 3: number of requesting harts (≥2).
- `MAX_OUTSTANDING`, 2: depth of response-ID FIFO, i.e. maximum granted-but-unanswered transactions (≥1).

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `core_req_i`  in  `obi_req_t[NHARTS]`  per-hart data requests.
- `core_resp_o`  out  `obi_resp_t[NHARTS]`  per-hart gnt/rvalid/rdata.
- `bus_req_o`  out  `obi_req_t`  shared bus request.
- `bus_resp_i`  in  `obi_resp_t`  shared bus response.
- `outstanding_o`  out  `$clog2(MAX_OUTSTANDING+1)`  current FIFO occupancy.
- `err_o`  out  1  sticky: `rvalid` received with empty FIFO.

## Operation
- Candidate set = harts with `core_req_i[h].req`=1.
- Selection: if `lock_q` set, `sel = lock_id_q`; else first candidate scanning `rr_ptr_q, rr_ptr_q+1, … mod NHARTS`.
- `bus_req_o` = `core_req_i[sel]` (addr, we, be, wdata); `bus_req_o.req` = candidate exists AND occupancy < `MAX_OUTSTANDING`. With no candidate: `bus_req_o` = all zero.
- Handshake (`bus_req_o.req & bus_resp_i.gnt`): `core_resp_o[sel].gnt`=1; push `sel` into ID FIFO; `rr_ptr_q <= (sel+1) mod NHARTS`; clear lock.
- Lock: `bus_req_o.req`=1 and `gnt`=0 → `lock_q<=1`, `lock_id_q<=sel`; guarantees addr/we/be/wdata stay sourced from the same hart until granted (harts hold their request per OBI). Lock also engages when blocked only by full FIFO? No: lock tracks only presented requests (`bus_req_o.req`=1).
- `gnt` to non-selected harts always 0.
- Response: `bus_resp_i.rvalid`=1 and FIFO non-empty → `core_resp_o[head].rvalid`=1, `rdata`=`bus_resp_i.rdata`; pop. Other harts: rvalid=0, rdata=0.
- `rvalid` with empty FIFO → dropped, `err_o<=1` (cleared only by reset).
- Simultaneous push and pop: both occur; occupancy unchanged. Full-FIFO check uses registered occupancy only (same-cycle pop does not unblock a request).
- FIFO pointers wrap modulo `MAX_OUTSTANDING`; occupancy never exceeds `MAX_OUTSTANDING` nor underflows.
- `rvalid` in the same cycle as `gnt` always refers to an older transaction (OBI: rvalid earliest one cycle after gnt).

## Timing
- Grant path combinational: `core_req_i` → `bus_req_o` and `bus_resp_i.gnt` → `core_resp_o.gnt` in the same cycle (zero added latency).
- Response path combinational from FIFO head register: `bus_resp_i.rvalid` → `core_resp_o[head].rvalid` same cycle.
- State updates on rising `clk_i`: `rr_ptr_q`, `lock_q`, `lock_id_q`, FIFO entries/pointers, occupancy, `err_o`.
- Reset values: `rr_ptr_q`=0, `lock_q`=0, `lock_id_q`=0, FIFO empty, `outstanding_o`=0, `err_o`=0; consequently `bus_req_o.req`=0 unless a hart requests, all `core_resp_o` fields 0.
- Reset mid-operation: outstanding IDs discarded; any later `rvalid` with empty FIFO sets `err_o`.

## Configuration
- `EXT_CPU_ARB_FIXED_PRIO_EN`: defined → fixed priority, lowest hart index wins (`rr_ptr_q` held at 0, not updated); lock behaviour unchanged. Undefined → round-robin as in Operation.

## Test plan
- Reset then idle: all outputs 0, `outstanding_o`=0, `err_o`=0.
- Harts 0,1,2 request continuously, bus `gnt`=1 every cycle, `rvalid` one cycle later → grants 0,1,2,0,…; rdata 0xA0,0xA1,0xA2 delivered to harts 0,1,2 in order.
- Hart 1 requests, `gnt` held low 3 cycles while hart 0 starts requesting → bus keeps hart 1's addr; hart 1 granted first, then hart 0.
- `MAX_OUTSTANDING`=2, two grants with no `rvalid` → `bus_req_o.req`=0 despite pending hart; one `rvalid` → next cycle request reissued.
- `rvalid`=1 with empty FIFO → no hart sees rvalid, `err_o`=1 held until `rst_i`.
- With `EXT_CPU_ARB_FIXED_PRIO_EN`, harts 0 and 2 requesting continuously → hart 0 granted every cycle, hart 2 never.
